emu_time_scheduler: RTL and testbench

EMU_TIME_SCHEDULER -- requirements
Module: emu_time_scheduler

---
 rtl/emu_time_scheduler.sv | 102 ++++++++++
 tb/tb_emu_time_scheduler.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/emu_time_scheduler.sv
// Emulation time scheduler: captures per-oscillator step requests, scans for the
// smallest one lane per cycle, then commits it as the global timestep.
`ifndef DT_WIDTH
`define DT_WIDTH 8
`endif

module emu_time_scheduler #(
    parameter int unsigned         N_CLK      = 2,
    parameter int unsigned         DT_WIDTH   = `DT_WIDTH,
    parameter int unsigned         TIME_WIDTH = 39,
    parameter logic [DT_WIDTH-1:0] DT_MAX     = '1
) (
    input  logic                        emu_clk,
    input  logic                        emu_rst_n,
    input  logic                        emu_stall,
    input  logic [N_CLK*DT_WIDTH-1:0]   dt_req,
    output logic [DT_WIDTH-1:0]         emu_dt,
    output logic                        step_valid,
    output logic [N_CLK-1:0]            clk_en,
    output logic [TIME_WIDTH-1:0]       emu_time
);

    localparam int unsigned IDX_W = (N_CLK > 1) ? $clog2(N_CLK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLK - 1);

    typedef enum logic [1:0] {
        LOAD,
        SCAN,
        COMMIT
    } state_t;

    state_t              state;
    logic [DT_WIDTH-1:0] dt_cap [N_CLK];
    logic [DT_WIDTH-1:0] min_q;
    logic [IDX_W-1:0]    idx_q;

    logic [DT_WIDTH-1:0] lane_cur;
    logic [DT_WIDTH-1:0] min_nxt;
    logic [N_CLK-1:0]    en_nxt;

    function automatic logic [DT_WIDTH-1:0] clamp(input logic [DT_WIDTH-1:0] v);
        return (v > DT_MAX) ? DT_MAX : v;
    endfunction

    // min_nxt already folds in the lane being scanned, so the last SCAN edge
    // can commit the final minimum and its enables in the same cycle.
    always_comb begin
        lane_cur = dt_cap[idx_q];
        min_nxt  = (lane_cur < min_q) ? lane_cur : min_q;
        en_nxt   = '0;
        for (int unsigned i = 0; i < N_CLK; i++) begin
            en_nxt[i] = (dt_cap[i] == min_nxt);
        end
    end

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state      <= LOAD;
            min_q      <= '0;
            idx_q      <= '0;
            emu_dt     <= '0;
            step_valid <= 1'b0;
            clk_en     <= '0;
            emu_time   <= '0;
            for (int unsigned i = 0; i < N_CLK; i++) begin
                dt_cap[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (!emu_stall) begin
                        for (int unsigned i = 0; i < N_CLK; i++) begin
                            dt_cap[i] <= clamp(dt_req[i*DT_WIDTH +: DT_WIDTH]);
                        end
                        min_q <= DT_MAX;
                        idx_q <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    min_q <= min_nxt;
                    if (idx_q == LAST_IDX) begin
                        emu_dt     <= min_nxt;
                        clk_en     <= en_nxt;
                        emu_time   <= emu_time + TIME_WIDTH'(min_nxt);
                        step_valid <= 1'b1;
                        state      <= COMMIT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                COMMIT: begin
                    step_valid <= 1'b0;
                    clk_en     <= '0;
                    state      <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_emu_time_scheduler.sv
// Randomized bench for emu_time_scheduler against a transaction-level model:
// each step's result is the clamped minimum of the lanes sampled at release.
module tb_emu_time_scheduler;

    localparam int unsigned N_CLK      = 2;
    localparam int unsigned DT_WIDTH   = 8;
    localparam int unsigned TIME_WIDTH = 12;
    localparam int unsigned DT_MAX     = 200;

    logic                      emu_clk = 1'b0;
    logic                      emu_rst_n;
    logic                      emu_stall;
    logic [N_CLK*DT_WIDTH-1:0] dt_req;
    logic [DT_WIDTH-1:0]       emu_dt;
    logic                      step_valid;
    logic [N_CLK-1:0]          clk_en;
    logic [TIME_WIDTH-1:0]     emu_time;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned model_time = 0;
    int unsigned model_dt   = 0;

    emu_time_scheduler #(
        .N_CLK      (N_CLK),
        .DT_WIDTH   (DT_WIDTH),
        .TIME_WIDTH (TIME_WIDTH),
        .DT_MAX     (8'(DT_MAX))
    ) dut (
        .emu_clk    (emu_clk),
        .emu_rst_n  (emu_rst_n),
        .emu_stall  (emu_stall),
        .dt_req     (dt_req),
        .emu_dt     (emu_dt),
        .step_valid (step_valid),
        .clk_en     (clk_en),
        .emu_time   (emu_time)
    );

    always #5 emu_clk = ~emu_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_valid"}, 32'(step_valid), 32'd0);
        check_eq({tag, "_clk_en"}, 32'(clk_en), 32'd0);
        check_eq({tag, "_dt"}, 32'(emu_dt), model_dt);
        check_eq({tag, "_time"}, 32'(emu_time), model_time);
    endtask

    // Entered at a falling edge while the DUT waits in LOAD; returns likewise.
    task automatic run_step(input int unsigned l0, input int unsigned l1,
                            input int unsigned stall_cyc, input bit do_reset);
        int unsigned lane [N_CLK];
        int unsigned mn;
        logic [N_CLK-1:0] exp_en;
        for (int unsigned s = 0; s < stall_cyc; s++) begin
            emu_stall = 1'b1;
            dt_req    = 16'($urandom);
            @(negedge emu_clk);
            check_idle("stall");
        end
        emu_stall = 1'b0;
        dt_req    = {8'(l1), 8'(l0)};
        for (int unsigned k = 1; k <= N_CLK; k++) begin
            @(negedge emu_clk);
            check_eq("scan_valid", 32'(step_valid), 32'd0);
            dt_req    = 16'($urandom);
            emu_stall = 1'($urandom);
            if (do_reset && k == 1) begin
                emu_rst_n = 1'b0;
                #1;
                model_time = 0;
                model_dt   = 0;
                check_idle("abort");
                @(negedge emu_clk);
                emu_rst_n = 1'b1;
                emu_stall = 1'b0;
                return;
            end
        end
        @(negedge emu_clk);
        lane[0] = (l0 > DT_MAX) ? DT_MAX : l0;
        lane[1] = (l1 > DT_MAX) ? DT_MAX : l1;
        mn = DT_MAX;
        foreach (lane[i]) if (lane[i] < mn) mn = lane[i];
        foreach (lane[i]) exp_en[i] = (lane[i] == mn);
        model_dt   = mn;
        model_time = (model_time + mn) % (1 << TIME_WIDTH);
        check_eq("commit_valid", 32'(step_valid), 32'd1);
        check_eq("commit_dt", 32'(emu_dt), model_dt);
        check_eq("commit_clk_en", 32'(clk_en), 32'(exp_en));
        check_eq("commit_time", 32'(emu_time), model_time);
        emu_stall = 1'b0;
        @(negedge emu_clk);
        check_idle("post");
    endtask

    task automatic do_reset_pulse();
        emu_rst_n = 1'b0;
        @(negedge emu_clk);
        model_time = 0;
        model_dt   = 0;
        check_idle("reset");
        emu_rst_n = 1'b1;
    endtask

    initial begin
        int unsigned mode, a, b;
        emu_rst_n = 1'b0;
        emu_stall = 1'b0;
        dt_req    = '0;
        repeat (3) @(negedge emu_clk);
        check_idle("por");
        emu_rst_n = 1'b1;

        run_step(30, 50, 0, 0);
        check_eq("basic_time", 32'(emu_time), 32'd30);
        run_step(30, 50, 0, 0);
        check_eq("basic_time2", 32'(emu_time), 32'd60);
        run_step(40, 40, 0, 0);
        run_step(250, 230, 0, 0);
        run_step(0, 5, 0, 0);
        run_step(77, 12, 10, 0);

        do_reset_pulse();
        for (int unsigned i = 0; i < 20; i++) run_step(200, 250, 0, 0);
        run_step(90, 255, 0, 0);
        check_eq("pre_wrap_time", 32'(emu_time), 32'd4090);
        run_step(10, 10, 0, 0);
        check_eq("wrap_time", 32'(emu_time), 32'd4);

        run_step(60, 70, 0, 1);
        run_step(25, 35, 0, 0);
        check_eq("after_abort_time", 32'(emu_time), 32'd25);

        for (int unsigned n = 0; n < 150; n++) begin
            mode = $urandom_range(0, 5);
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            case (mode)
                3: b = a;
                4: a = 0;
                5: begin a = $urandom_range(200, 255); b = $urandom_range(200, 255); end
                default: ;
            endcase
            run_step(a, b, $urandom_range(0, 3), ($urandom_range(0, 39) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
